// File: rtl/processor_pkg.sv
// Shared processor definitions: bus widths, responder states
// and the memory opcodes used by the core and its memory side.
package processor_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    localparam logic [3:0] OPC_LOAD  = 4'b0001;
    localparam logic [3:0] OPC_STORE = 4'b0010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input int unsigned depth
    );
        return addr < depth;
    endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port synchronous word RAM: registered read, write enable,
// no reset on either the array or the read register.
module mem_array_sp #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // one access per edge; read register holds when re is low
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/processor_mem_responder.sv
// Memory-side responder: latches one request, counts wait states,
// then commits/reads the RAM and pulses ack with range error.
module processor_mem_responder
    import processor_pkg::*;
#(
    parameter int          ADDR_W      = processor_pkg::ADDR_W,
    parameter int          DATA_W      = processor_pkg::DATA_W,
    parameter int unsigned DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data,
    output logic              ack,
    output logic              busy,
    output logic              error
);

    localparam int RAM_AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    resp_state_t state_q;
    resp_state_t state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        enter_resp;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              in_range;

    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_q;

    logic ack_q;
    logic err_q;
    logic busy_q;
    logic zero_q;

    // with no wait states the access happens on the accepting edge,
    // so the live bus is used instead of the latch
    assign acc_we    = (state_q == IDLE) ? we      : we_q;
    assign acc_addr  = (state_q == IDLE) ? address : addr_q;
    assign acc_wdata = (state_q == IDLE) ? in_data : wdata_q;
    assign in_range  = addr_in_range(32'(acc_addr), DEPTH);

    assign ram_we = enter_resp & acc_we & in_range & ~reset;
    assign ram_re = enter_resp & ~acc_we & in_range & ~reset;

    // next state, wait counter and the RESP-entry strobe
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state register and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= enter_resp;
            err_q   <= enter_resp & ~in_range;
            busy_q  <= (state_d != IDLE);
            if (enter_resp) begin
                if (!in_range) begin
                    zero_q <= 1'b1;
                end else if (!acc_we) begin
                    zero_q <= 1'b0;
                end
            end
        end
    end

    // request latch; bus changes after acceptance are not seen
    always_ff @(posedge clock) begin
        if (state_q == IDLE && req) begin
            we_q    <= we;
            addr_q  <= address;
            wdata_q <= in_data;
        end
    end

    mem_array_sp #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_mem (
        .clock (clock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (acc_addr[RAM_AW-1:0]),
        .wdata (acc_wdata),
        .rdata (ram_q)
    );

    // zero_q masks the un-reset RAM register after reset
    // and for out-of-range responses
    assign out_data = zero_q ? '0 : ram_q;
    assign ack      = ack_q;
    assign error    = err_q;
    assign busy     = busy_q;

endmodule
